// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and small helpers.
// Used by vga_timing_gen and vga_axis_counter.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Asserted sync level; VGA 640x480 uses negative sync.
  localparam logic VGA_SYNC_POL = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter, sync window flop and active-window flag.
// Sync is registered from the next-state count so it lines up with the count itself.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = VGA_H_ACTIVE,
  parameter int   FP     = VGA_H_FP,
  parameter int   SYNC   = VGA_H_SYNC,
  parameter int   BP     = VGA_H_BP,
  parameter logic POL    = VGA_SYNC_POL
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  output coord_t cnt_d_o,
  output logic   wrap_o,
  output logic   active_d_o,
  output logic   sync_o
);

  localparam coord_t LAST    = COORD_W'(ACTIVE + FP + SYNC + BP - 1);
  localparam coord_t SYNC_LO = COORD_W'(ACTIVE + FP);
  localparam coord_t SYNC_HI = COORD_W'(ACTIVE + FP + SYNC - 1);
  localparam coord_t ACT_END = COORD_W'(ACTIVE);
  localparam coord_t ONE     = COORD_W'(1);

  coord_t cnt_q;
  coord_t cnt_d;
  logic   sync_q;
  logic   sync_d;
  logic   wrap_s;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_s = 1'b0;
    if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        wrap_s = 1'b1;
      end else begin
        cnt_d  = cnt_q + ONE;
        wrap_s = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
    sync_d = in_window(cnt_d, SYNC_LO, SYNC_HI) ? POL : ~POL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_d_o    = cnt_d;
  assign wrap_o     = wrap_s;
  assign active_d_o = (cnt_d < ACT_END);
  assign sync_o     = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: syncs, active flag, pixel coordinates, line/frame pulses.
// Define VGA_PIXDIV2_EN to run from a 2x pixel clock with an internal divide-by-2 tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = VGA_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst,
  output logic               h_sync,
  output logic               v_sync,
  output logic               active,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start
);

  logic   pix_tick_s;
  coord_t h_cnt_d;
  coord_t v_cnt_d;
  logic   h_wrap_s;
  logic   v_wrap_s;
  logic   h_act_d;
  logic   v_act_d;
  logic   h_sync_s;
  logic   v_sync_s;

  logic   active_d;
  coord_t x_d;
  coord_t y_d;
  logic   active_q;
  coord_t x_q;
  coord_t y_q;
  logic   line_start_q;
  logic   frame_start_q;

`ifdef VGA_PIXDIV2_EN
  logic div_q;

  // Divide-by-2 toggle: tick is high on every second clk, first on the 2nd after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
    end
  end

  assign pix_tick_s = div_q;
`else
  assign pix_tick_s = 1'b1;
`endif

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (SYNC_POL)
  ) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .en_i       (pix_tick_s),
    .cnt_d_o    (h_cnt_d),
    .wrap_o     (h_wrap_s),
    .active_d_o (h_act_d),
    .sync_o     (h_sync_s)
  );

  // Vertical advances only on the horizontal wrap, so its wrap is also the frame wrap.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (SYNC_POL)
  ) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .en_i       (h_wrap_s),
    .cnt_d_o    (v_cnt_d),
    .wrap_o     (v_wrap_s),
    .active_d_o (v_act_d),
    .sync_o     (v_sync_s)
  );

  always_comb begin
    active_d = h_act_d && v_act_d;
    x_d      = '0;
    y_d      = '0;
    if (active_d) begin
      x_d = h_cnt_d;
      y_d = v_cnt_d;
    end else begin
      x_d = '0;
      y_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= h_wrap_s;
      frame_start_q <= v_wrap_s;
    end
  end

  assign h_sync      = h_sync_s;
  assign v_sync      = v_sync_s;
  assign active      = active_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign pix_tick    = pix_tick_s;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-width lines with a shortened vertical
// frame (6 active, 2 fp, 2 sync, 2 bp lines) so whole frames fit a short run.
module tb_vga_timing_gen;

  localparam int HT  = 800;
  localparam int VA  = 6;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int VT  = VA + VFP + VSW + VBP;
`ifdef VGA_PIXDIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       h_sync, v_sync, active, pix_tick, line_start, frame_start;
  logic [9:0] x_pos, y_pos;

  int total = 0;
  int bad   = 0;
  int eh = 0, ev = 0;
  int clk_cnt = 0, ls_clk = 0, vs_low = 0, fs_seen = 0, hs_falls = 0, vs_falls = 0;
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  logic [31:0] rst_vec;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_BP     (VBP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .active      (active),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .pix_tick    (pix_tick),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {7'd0, h_sync, v_sync, active, x_pos, y_pos, line_start, frame_start};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic       act, hs, vs, ls, fs;
    logic [9:0] x, y;
    act = (eh < 640) && (ev < VA);
    x   = act ? 10'(eh) : 10'd0;
    y   = act ? 10'(ev) : 10'd0;
    hs  = !((eh >= 656) && (eh <= 751));
    vs  = !((ev >= VA + VFP) && (ev <= VA + VFP + VSW - 1));
    ls  = (eh == 0);
    fs  = (eh == 0) && (ev == 0);
    return {7'd0, hs, vs, act, x, y, ls, fs};
  endfunction

  task automatic clk_edge();
    @(negedge clk);
    clk_cnt++;
    if (line_start === 1'b1) ls_clk++;
  endtask

  // Advance exactly one pixel and move the reference raster position with it.
  task automatic tick();
    int guard = 0;
    while (pix_tick !== 1'b1 && guard < 4) begin
      clk_edge();
      guard++;
    end
    if (guard >= 4) check("pix_tick_timeout", {31'd0, pix_tick}, 32'd1);
    clk_edge();
    eh++;
    if (eh == HT) begin
      eh = 0;
      ev++;
      if (ev == VT) ev = 0;
    end
  endtask

  task automatic step();
    tick();
    check("raster", obs_vec(), exp_vec());
    if (prev_hs === 1'b1 && h_sync === 1'b0) hs_falls++;
    if (prev_vs === 1'b1 && v_sync === 1'b0) begin
      if (vs_falls > 0) check("hsync_per_frame", 32'(hs_falls), 32'(VT));
      hs_falls = 0;
      vs_falls++;
    end
    if (v_sync === 1'b0) vs_low++;
    if (frame_start === 1'b1) begin
      check("vsync_low_ticks", 32'(vs_low), 32'd1600);
      vs_low = 0;
      fs_seen++;
    end
    prev_hs = h_sync;
    prev_vs = v_sync;
  endtask

  initial begin
    int guard;
    rst_vec = {7'd0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vec", obs_vec(), rst_vec);
`ifdef VGA_PIXDIV2_EN
    check("pix_tick_rst", {31'd0, pix_tick}, 32'd0);
`else
    check("pix_tick_const", {31'd0, pix_tick}, 32'd1);
`endif
    rst = 1'b0;
    #1;
    check("release_vec", obs_vec(), rst_vec);

    // First line: h_sync window, first tick lands on h=1, single line_start.
    clk_cnt = 0;
    ls_clk  = 0;
    for (int i = 0; i < HT; i++) step();
    check("first_line_clks", 32'(clk_cnt), 32'(HT * DIV));
    check("line_start_clks", 32'(ls_clk), 32'd1);

    // Two complete frame wraps.
    guard = 0;
    while (fs_seen < 2 && guard < 3 * VT * HT) begin
      step();
      guard++;
    end
    check("frame_starts", 32'(fs_seen), 32'd2);

    // Last visible pixel and the one after it.
    guard = 0;
    while (!(eh == 639 && ev == VA - 1) && guard < 2 * VT * HT) begin
      step();
      guard++;
    end
    check("last_px_active", {31'd0, active}, 32'd1);
    check("last_px_x", {22'd0, x_pos}, 32'd639);
    check("last_px_y", {22'd0, y_pos}, 32'(VA - 1));
    step();
    check("after_last_active", {31'd0, active}, 32'd0);
    check("after_last_x", {22'd0, x_pos}, 32'd0);

    // Reset in mid-frame must act without waiting for a clock edge.
    guard = 0;
    while (!(eh == 300 && ev == 3) && guard < 2 * VT * HT) begin
      step();
      guard++;
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_vec", obs_vec(), rst_vec);
    @(negedge clk);
    check("held_rst_vec", obs_vec(), rst_vec);
    rst      = 1'b0;
    eh       = 0;
    ev       = 0;
    prev_hs  = 1'b1;
    prev_vs  = 1'b1;
    vs_low   = 0;
    hs_falls = 0;
    vs_falls = 0;
    step();
    check("restart_x", {22'd0, x_pos}, 32'd1);
    for (int i = 0; i < 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
